// File: rtl/pipe_retire_if.sv
`default_nettype none
// ============================================================================
//  Module      : pipe_retire_if
//  Description : W-stage retirement bus between the Y86 pipeline writeback
//                stage (master) and the retirement/status controller (slave).
//  Revision    : 1.0  initial release
// ============================================================================
interface pipe_retire_if #(
    parameter int CNT_W = 32
);
    // W-stage inputs to the controller
    logic [2:0]       w_status;
    logic [3:0]       w_icode;
    logic             w_bubble;
    // Architectural status and control back to the pipeline
    logic [2:0]       stat;
    logic             run_en;
    logic             halted;
    logic             timeout;
    logic [CNT_W-1:0] cycle_cnt;
    logic [CNT_W-1:0] instr_cnt;
    logic             retire;

    // Pipeline side: presents W-stage state, observes status/control
    modport master (
        output w_status, w_icode, w_bubble,
        input  stat, run_en, halted, timeout, cycle_cnt, instr_cnt, retire
    );

    // Controller side
    modport slave (
        input  w_status, w_icode, w_bubble,
        output stat, run_en, halted, timeout, cycle_cnt, instr_cnt, retire
    );
endinterface
`default_nettype wire

// File: rtl/pipe_retire_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : pipe_retire_ctrl
//  Description : Writeback-side retirement and program-status controller.
//                Decodes the W-stage status/icode of each real instruction,
//                drives the architectural status (AOK/INS/HLT), the global
//                pipeline run enable, saturating cycle/instruction counters,
//                a retire pulse and a cycle-limit watchdog.
//  Revision    : 1.0  initial release
// ============================================================================
module pipe_retire_ctrl #(
    parameter int CNT_W      = 32,
    parameter int MAX_CYCLES = 1000
) (
    input  wire logic        clk,
    input  wire logic        rst,
    pipe_retire_if.slave     bus
);

    localparam logic [2:0]       c_stat_aok = 3'b001;
    localparam logic [2:0]       c_stat_ins = 3'b010;
    localparam logic [2:0]       c_stat_hlt = 3'b100;
    localparam logic [CNT_W-1:0] c_cnt_max  = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] c_cnt_one  = CNT_W'(1);

    typedef enum logic [1:0] {
        ST_RUN     = 2'd0,
        ST_HALT    = 2'd1,
        ST_ERR     = 2'd2,
        ST_TIMEOUT = 2'd3
    } state_t;

    state_t           r_state;
    logic [2:0]       r_stat;
    logic             r_run_en;
    logic             r_halted;
    logic             r_timeout;
    logic [CNT_W-1:0] r_cycle;
    logic [CNT_W-1:0] r_instr;
    logic             r_retire;

    logic             w_real;
    logic             w_onehot;
    logic             w_is_ins;
    logic             w_is_hlt;
    logic             w_wdog_hit;
    logic [CNT_W-1:0] w_cycle_inc;
    logic [CNT_W-1:0] w_instr_inc;

    // Instruction decode: INS outranks HLT; bubbles never decode as anything
    assign w_real   = ~bus.w_bubble;
    assign w_onehot = (bus.w_status == 3'b001) || (bus.w_status == 3'b010) ||
                      (bus.w_status == 3'b100);
    assign w_is_ins = w_real && (bus.w_status[1] || (bus.w_icode > 4'hB) || !w_onehot);
    assign w_is_hlt = w_real && !w_is_ins && (bus.w_status[2] || (bus.w_icode == 4'h0));

    // Saturating increments: counters stick at all-ones instead of wrapping
    assign w_cycle_inc = (r_cycle == c_cnt_max) ? r_cycle : r_cycle + c_cnt_one;
    assign w_instr_inc = (r_instr == c_cnt_max) ? r_instr : r_instr + c_cnt_one;

    // Watchdog compare. A limit the counter can never reach (it saturates
    // first) is treated the same as a disabled watchdog.
    generate
        if (MAX_CYCLES == 0 || $clog2(MAX_CYCLES) > CNT_W) begin : g_wdog_off
            assign w_wdog_hit = 1'b0;
        end else begin : g_wdog_on
            localparam logic [CNT_W-1:0] c_wdog_last = CNT_W'(MAX_CYCLES - 1);
            assign w_wdog_hit = (r_cycle == c_wdog_last);
        end
    endgenerate

    // Retirement FSM with registered status, control, counters and retire pulse
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= ST_RUN;
            r_stat    <= c_stat_aok;
            r_run_en  <= 1'b1;
            r_halted  <= 1'b0;
            r_timeout <= 1'b0;
            r_cycle   <= '0;
            r_instr   <= '0;
            r_retire  <= 1'b0;
        end else begin
            r_retire <= 1'b0;
            case (r_state)
                ST_RUN: begin
                    // Every RUN edge counts, including the one that leaves RUN
                    r_cycle <= w_cycle_inc;
                    if (w_is_ins) begin
                        // Faulting instruction is not counted as retired
                        r_state  <= ST_ERR;
                        r_stat   <= c_stat_ins;
                        r_run_en <= 1'b0;
                        r_halted <= 1'b1;
                    end else if (w_is_hlt) begin
                        // The halt itself does retire
                        r_state  <= ST_HALT;
                        r_stat   <= c_stat_hlt;
                        r_run_en <= 1'b0;
                        r_halted <= 1'b1;
                        r_instr  <= w_instr_inc;
                        r_retire <= 1'b1;
                    end else begin
                        if (w_real) begin
                            r_instr  <= w_instr_inc;
                            r_retire <= 1'b1;
                        end
                        // Watchdog only fires when no INS/HLT claimed this edge
                        if (w_wdog_hit) begin
                            r_state   <= ST_TIMEOUT;
                            r_timeout <= 1'b1;
                            r_run_en  <= 1'b0;
                            r_halted  <= 1'b1;
                        end
                    end
                end
                // Terminal states: everything holds until reset
                ST_HALT, ST_ERR, ST_TIMEOUT: begin
                    r_state <= r_state;
                end
                default: begin
                    r_state <= ST_RUN;
                end
            endcase
        end
    end

    assign bus.stat      = r_stat;
    assign bus.run_en    = r_run_en;
    assign bus.halted    = r_halted;
    assign bus.timeout   = r_timeout;
    assign bus.cycle_cnt = r_cycle;
    assign bus.instr_cnt = r_instr;
    assign bus.retire    = r_retire;

endmodule
`default_nettype wire

// File: tb/tb_pipe_retire_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_pipe_retire_ctrl
//  Description : Self-checking bench for pipe_retire_ctrl. Three instances
//                (default limits, short watchdog, narrow counters) receive the
//                same W-stage stimulus and are compared every cycle against
//                a behavioural model of the retirement rules.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_pipe_retire_ctrl;

    logic clk;
    logic rst;

    int total;
    int bad;

    pipe_retire_if #(.CNT_W(32)) if_a ();
    pipe_retire_if #(.CNT_W(32)) if_b ();
    pipe_retire_if #(.CNT_W(3))  if_c ();

    pipe_retire_ctrl #(.CNT_W(32), .MAX_CYCLES(1000)) u_dut_a (.clk(clk), .rst(rst), .bus(if_a));
    pipe_retire_ctrl #(.CNT_W(32), .MAX_CYCLES(8))    u_dut_b (.clk(clk), .rst(rst), .bus(if_b));
    pipe_retire_ctrl #(.CNT_W(3),  .MAX_CYCLES(0))    u_dut_c (.clk(clk), .rst(rst), .bus(if_c));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Model: mode 0=running, 1=halted, 2=error, 3=timed out
    int              m_w   [3];
    int              m_max [3];
    int              m_mode[3];
    longint unsigned m_cyc [3];
    longint unsigned m_ins [3];
    bit              m_ret [3];

    task automatic check(input string tag, input longint unsigned got, input longint unsigned exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic model_step(input int i, input bit r, input logic [2:0] st,
                              input logic [3:0] ic, input bit bub);
        longint unsigned cap;
        bit is_ins, is_hlt;
        cap = (64'd1 << m_w[i]) - 64'd1;
        m_ret[i] = 1'b0;
        if (r) begin
            m_mode[i] = 0;
            m_cyc[i]  = 0;
            m_ins[i]  = 0;
            return;
        end
        if (m_mode[i] != 0) return;
        is_ins = !bub && (st[1] || ic > 4'hB || $countones(st) != 1);
        is_hlt = !bub && !is_ins && (st[2] || ic == 4'h0);
        if (is_ins) begin
            m_mode[i] = 2;
        end else if (is_hlt) begin
            m_mode[i] = 1;
            if (m_ins[i] < cap) m_ins[i]++;
            m_ret[i] = 1'b1;
        end else begin
            if (!bub) begin
                if (m_ins[i] < cap) m_ins[i]++;
                m_ret[i] = 1'b1;
            end
            if (m_max[i] > 0 && m_cyc[i] == longint'(m_max[i] - 1)) m_mode[i] = 3;
        end
        if (m_cyc[i] < cap) m_cyc[i]++;
    endtask

    task automatic compare_dut(input int i, input logic [2:0] st, input logic ren,
                               input logic hlt, input logic tmo, input longint unsigned cyc,
                               input longint unsigned ins, input logic ret);
        longint unsigned exp_stat;
        exp_stat = (m_mode[i] == 1) ? 3'b100 : (m_mode[i] == 2) ? 3'b010 : 3'b001;
        check($sformatf("stat[%0d]", i),    st,  exp_stat);
        check($sformatf("run_en[%0d]", i),  ren, (m_mode[i] == 0) ? 1 : 0);
        check($sformatf("halted[%0d]", i),  hlt, (m_mode[i] != 0) ? 1 : 0);
        check($sformatf("timeout[%0d]", i), tmo, (m_mode[i] == 3) ? 1 : 0);
        check($sformatf("cycle[%0d]", i),   cyc, m_cyc[i]);
        check($sformatf("instr[%0d]", i),   ins, m_ins[i]);
        check($sformatf("retire[%0d]", i),  ret, m_ret[i]);
    endtask

    // One clock: drive inputs, advance model on the edge, compare 1 time unit later
    task automatic step(input bit r, input logic [2:0] st, input logic [3:0] ic, input bit bub);
        rst = r;
        if_a.w_status = st; if_a.w_icode = ic; if_a.w_bubble = bub;
        if_b.w_status = st; if_b.w_icode = ic; if_b.w_bubble = bub;
        if_c.w_status = st; if_c.w_icode = ic; if_c.w_bubble = bub;
        @(posedge clk);
        for (int i = 0; i < 3; i++) model_step(i, r, st, ic, bub);
        #1;
        compare_dut(0, if_a.stat, if_a.run_en, if_a.halted, if_a.timeout,
                    longint'(if_a.cycle_cnt), longint'(if_a.instr_cnt), if_a.retire);
        compare_dut(1, if_b.stat, if_b.run_en, if_b.halted, if_b.timeout,
                    longint'(if_b.cycle_cnt), longint'(if_b.instr_cnt), if_b.retire);
        compare_dut(2, if_c.stat, if_c.run_en, if_c.halted, if_c.timeout,
                    longint'(if_c.cycle_cnt), longint'(if_c.instr_cnt), if_c.retire);
    endtask

    task automatic aok(input int n);
        for (int k = 0; k < n; k++) step(1'b0, 3'b001, 4'h6, 1'b0);
    endtask

    task automatic do_reset();
        step(1'b1, 3'b001, 4'h6, 1'b0);
    endtask

    initial begin
        logic [2:0] st;
        logic [3:0] ic;
        bit         bub;
        int         sel;

        total = 0;
        bad   = 0;
        m_w   = '{32, 32, 3};
        m_max = '{1000, 8, 0};
        for (int i = 0; i < 3; i++) begin
            m_mode[i] = 0; m_cyc[i] = 0; m_ins[i] = 0; m_ret[i] = 0;
        end
        rst = 1'b1;
        if_a.w_status = 3'b001; if_a.w_icode = 4'h6; if_a.w_bubble = 1'b1;
        if_b.w_status = 3'b001; if_b.w_icode = 4'h6; if_b.w_bubble = 1'b1;
        if_c.w_status = 3'b001; if_c.w_icode = 4'h6; if_c.w_bubble = 1'b1;

        // Reset state and plain retirement
        do_reset();
        check("reset_stat", if_a.stat, 3'b001);
        check("reset_cycle", longint'(if_a.cycle_cnt), 0);
        aok(5);
        check("t1_cycle", longint'(if_a.cycle_cnt), 5);
        check("t1_instr", longint'(if_a.instr_cnt), 5);

        // Halt after a mix of real and bubble cycles, then hold
        do_reset();
        aok(2);
        step(1'b0, 3'b010, 4'hF, 1'b1);
        aok(1);
        step(1'b0, 3'b100, 4'h0, 1'b0);
        check("t2_stat", if_a.stat, 3'b100);
        for (int k = 0; k < 10; k++) step(1'b0, 3'b001, 4'h6, 1'b0);
        check("t2_instr", longint'(if_a.instr_cnt), 4);
        check("t2_cycle", longint'(if_a.cycle_cnt), 5);

        // Invalid icode, and a bubble carrying INS status
        do_reset();
        aok(2);
        step(1'b0, 3'b001, 4'hD, 1'b0);
        check("t3_stat", if_a.stat, 3'b010);
        check("t3_instr", longint'(if_a.instr_cnt), 2);
        do_reset();
        step(1'b0, 3'b010, 4'h6, 1'b1);
        check("t3_bubble_run", if_a.run_en, 1);

        // Watchdog expiry, and halt winning on the expiry edge
        do_reset();
        aok(8);
        check("t4_timeout", if_b.timeout, 1);
        check("t4_cycle", longint'(if_b.cycle_cnt), 8);
        do_reset();
        aok(7);
        step(1'b0, 3'b100, 4'h0, 1'b0);
        check("t4_halt_wins", if_b.timeout, 0);
        check("t4_halt_stat", if_b.stat, 3'b100);

        // Reset from a terminal state and mid-run
        aok(2);
        do_reset();
        check("t5_run_en", if_b.run_en, 1);
        aok(3);
        do_reset();
        check("t5_mid_cycle", longint'(if_a.cycle_cnt), 0);

        // Narrow counters saturate
        aok(10);
        check("t6_cycle", longint'(if_c.cycle_cnt), 7);
        check("t6_instr", longint'(if_c.instr_cnt), 7);
        check("t6_timeout", if_c.timeout, 0);

        // Randomized traffic
        for (int k = 0; k < 3000; k++) begin
            sel = int'($urandom_range(0, 99));
            bub = 1'b0;
            if (sel < 10) begin
                bub = 1'b1;
                st  = 3'($urandom);
                ic  = 4'($urandom);
            end else if (sel < 13) begin
                st  = ($urandom_range(0, 1) == 0) ? 3'b100 : 3'b001;
                ic  = (st == 3'b001) ? 4'h0 : 4'($urandom);
            end else if (sel < 16) begin
                st  = 3'($urandom);
                ic  = 4'($urandom_range(0, 15));
            end else begin
                st  = 3'b001;
                ic  = 4'($urandom_range(1, 11));
            end
            step(($urandom_range(0, 99) < 3), st, ic, bub);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
